// File: rtl/prog_pkg.sv
// rtl/prog_pkg.sv - shared opcode, field and state definitions for the program sequencer
package prog_pkg;

    localparam int WORD_W = 8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_HALF = 2'b11;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 6;
    localparam int OPND_MSB = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program word storage, synchronous write and combinational read
module prog_ram
    import prog_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    // Contents survive reset; only the word count decides what is valid.
    logic [WORD_W-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    assign rdata = ram[raddr];

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - loads a small program while idle and streams it out word by word
module program_sequencer
    import prog_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              clear,
    input  logic              start,
    input  logic              loop,
    input  logic              stop,
    input  logic              hold,
    output logic [WORD_W-1:0] mem,
    output logic              mem_valid,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       count,
    output logic              overflow
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    seq_state_t        state;
    logic [AW-1:0]     rd_ptr;
    logic              loop_q;
    logic [AW-1:0]     wr_ptr;
    logic              full;
    logic              ram_we;
    logic              last_word;
    logic [WORD_W-1:0] ram_rdata;

    // The next free slot is always the current word count.
    assign wr_ptr    = count[AW-1:0];
    assign full      = (count >= FULL_CNT);
    assign ram_we    = (state == S_IDLE) && !clear && wr_en && !full;
    assign last_word = ({1'b0, rd_ptr} == (count - 1'b1));

    prog_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr),
        .wdata(wr_data),
        .raddr(rd_ptr),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            loop_q    <= 1'b0;
            mem       <= '0;
            mem_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        if (wr_en) begin
                            if (full) begin
                                overflow <= 1'b1;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                        if (start && (count != '0)) begin
                            loop_q <= loop;
                            rd_ptr <= '0;
                            busy   <= 1'b1;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else if (!hold) begin
                        mem       <= ram_rdata;
                        mem_valid <= 1'b1;
                        if (last_word) begin
                            if (loop_q) begin
                                rd_ptr <= '0;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_DONE;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer against a playback model
module tb_program_sequencer;
    import prog_pkg::*;

    logic       clk = 1'b0;
    logic       rst, wr_en, clear, start, loop, stop, hold;
    logic [7:0] wr_data;
    logic [7:0] mem;
    logic       mem_valid, busy, done, overflow;
    logic [4:0] count;

    program_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
        .start(start), .loop(loop), .stop(stop), .hold(hold), .mem(mem),
        .mem_valid(mem_valid), .busy(busy), .done(done), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prog_q[$];
    bit         m_ovf;
    logic [7:0] last_word;

    logic       obs_v[64], obs_d[64], obs_b[64];
    logic [7:0] obs_m[64];
    logic       exp_v[64], exp_d[64], exp_b[64];
    logic [7:0] exp_m[64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        wr_en = 1'b1; wr_data = w;
        tick();
        wr_en = 1'b0;
        if (prog_q.size() < 16) prog_q.push_back(w);
        else m_ovf = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        prog_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic start_run(input bit lp);
        loop = lp; start = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
    endtask

    task automatic capture(input int n, input logic [63:0] hold_pat,
                           input logic [63:0] stop_pat, input bit noise);
        for (int i = 0; i < n; i++) begin
            hold = hold_pat[i];
            stop = stop_pat[i];
            if (noise && i < 3) begin
                wr_en = 1'b1; wr_data = 8'hFF; start = 1'b1; clear = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0; clear = 1'b0;
            end
            tick();
            obs_v[i] = mem_valid; obs_d[i] = done; obs_b[i] = busy; obs_m[i] = mem;
        end
        hold = 1'b0; stop = 1'b0;
    endtask

    // Walks the stored program cycle by cycle: each non-held cycle emits the next word.
    task automatic model(input int n, input bit lp, input logic [63:0] hold_pat,
                         input logic [63:0] stop_pat);
        int idx = 0;
        int done_at = -1;
        bit fin = 1'b0;
        int len = prog_q.size();
        for (int i = 0; i < n; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = (i == done_at);
            if (!fin) begin
                if (stop_pat[i]) begin
                    fin = 1'b1; done_at = i + 1;
                end else if (!hold_pat[i]) begin
                    exp_v[i] = 1'b1;
                    last_word = prog_q[idx];
                    idx++;
                    if (idx == len) begin
                        if (lp) idx = 0;
                        else begin fin = 1'b1; done_at = i + 1; end
                    end
                end
            end
            exp_m[i] = last_word;
            exp_b[i] = !fin;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({mem, mem_valid, busy, done, count, overflow} !== 17'h0)
            $display("FAIL reset_hold: got mem=%h v=%b busy=%b done=%b count=%0d ovf=%b, expected all zero",
                     mem, mem_valid, busy, done, count, overflow);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({mem, mem_valid, busy, done, count, overflow} !== 17'h0)
            $display("FAIL reset_release: got mem=%h v=%b busy=%b done=%b count=%0d ovf=%b, expected all zero",
                     mem, mem_valid, busy, done, count, overflow);
        else n_pass++;
        last_word = 8'h00;
    endtask

    task automatic test_basic();
        logic [5:0] acc;
        logic [7:0] w;
        do_clear();
        load(8'h05); load(8'h43); load(8'h82); load(8'hC0);
        n_checks++;
        if (count !== 5'd4) $display("FAIL basic_count: got %0d expected 4", count);
        else n_pass++;
        start_run(1'b0);
        capture(7, 64'h0, 64'h0, 1'b0);
        model(7, 1'b0, 64'h0, 64'h0);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({obs_v[i], obs_d[i], obs_b[i], obs_m[i]} !== {exp_v[i], exp_d[i], exp_b[i], exp_m[i]})
                $display("FAIL basic cyc%0d: got v/d/b/mem=%b/%b/%b/%h expected %b/%b/%b/%h", i,
                         obs_v[i], obs_d[i], obs_b[i], obs_m[i], exp_v[i], exp_d[i], exp_b[i], exp_m[i]);
            else n_pass++;
        end
        acc = 6'd0;
        for (int i = 0; i < 7; i++) begin
            if (obs_v[i] === 1'b1) begin
                w = obs_m[i];
                case (w[OPC_MSB:OPC_LSB])
                    OP_LOAD: acc = w[OPND_MSB:0];
                    OP_ADD:  acc = acc + w[OPND_MSB:0];
                    OP_SUB:  acc = acc - w[OPND_MSB:0];
                    default: acc = acc >> 1;
                endcase
            end
        end
        n_checks++;
        if (acc !== 6'd3) $display("FAIL basic_acc: got %0d expected 3", acc);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_clear();
        for (int k = 1; k <= 17; k++) load(8'(k));
        n_checks++;
        if ({count, overflow} !== {5'd16, m_ovf})
            $display("FAIL ovf_flags: got count=%0d ovf=%b expected 16/%b", count, overflow, m_ovf);
        else n_pass++;
        start_run(1'b0);
        capture(20, 64'h0, 64'h0, 1'b0);
        model(20, 1'b0, 64'h0, 64'h0);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({obs_v[i], obs_d[i], obs_b[i], obs_m[i]} !== {exp_v[i], exp_d[i], exp_b[i], exp_m[i]})
                $display("FAIL ovf cyc%0d: got v/d/b/mem=%b/%b/%b/%h expected %b/%b/%b/%h", i,
                         obs_v[i], obs_d[i], obs_b[i], obs_m[i], exp_v[i], exp_d[i], exp_b[i], exp_m[i]);
            else n_pass++;
        end
        do_clear();
        n_checks++;
        if ({count, overflow} !== 6'd0)
            $display("FAIL ovf_clear: got count=%0d ovf=%b expected 0/0", count, overflow);
        else n_pass++;
    endtask

    task automatic test_loop_stop();
        logic [63:0] sp;
        sp = 64'h8;
        do_clear();
        load(8'h05); load(8'h41);
        start_run(1'b1);
        capture(7, 64'h0, sp, 1'b0);
        model(7, 1'b1, 64'h0, sp);
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({obs_v[i], obs_d[i], obs_b[i], obs_m[i]} !== {exp_v[i], exp_d[i], exp_b[i], exp_m[i]})
                $display("FAIL loop cyc%0d: got v/d/b/mem=%b/%b/%b/%h expected %b/%b/%b/%h", i,
                         obs_v[i], obs_d[i], obs_b[i], obs_m[i], exp_v[i], exp_d[i], exp_b[i], exp_m[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        logic [63:0] hp;
        hp = 64'h6;
        do_clear();
        load(8'h11); load(8'h52); load(8'hA3);
        start_run(1'b0);
        capture(8, hp, 64'h0, 1'b0);
        model(8, 1'b0, hp, 64'h0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({obs_v[i], obs_d[i], obs_b[i], obs_m[i]} !== {exp_v[i], exp_d[i], exp_b[i], exp_m[i]})
                $display("FAIL hold cyc%0d: got v/d/b/mem=%b/%b/%b/%h expected %b/%b/%b/%h", i,
                         obs_v[i], obs_d[i], obs_b[i], obs_m[i], exp_v[i], exp_d[i], exp_b[i], exp_m[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        load(8'h21); load(8'h22); load(8'h23);
        start_run(1'b0);
        capture(1, 64'h0, 64'h0, 1'b0);
        model(1, 1'b0, 64'h0, 64'h0);
        n_checks++;
        if ({obs_v[0], obs_b[0], obs_m[0]} !== {exp_v[0], exp_b[0], exp_m[0]})
            $display("FAIL rstrun_first: got v/b/mem=%b/%b/%h expected %b/%b/%h",
                     obs_v[0], obs_b[0], obs_m[0], exp_v[0], exp_b[0], exp_m[0]);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prog_q.delete(); m_ovf = 1'b0; last_word = 8'h00;
        n_checks++;
        if ({mem_valid, busy, done, count, overflow} !== 9'h0)
            $display("FAIL rstrun_flags: got v=%b busy=%b done=%b count=%0d ovf=%b expected all zero",
                     mem_valid, busy, done, count, overflow);
        else n_pass++;
        tick();
        n_checks++;
        if ({done, mem_valid} !== 2'b00)
            $display("FAIL rstrun_nodone: got done=%b v=%b expected 0/0", done, mem_valid);
        else n_pass++;
        start_run(1'b0);
        tick();
        n_checks++;
        if ({busy, mem_valid} !== 2'b00)
            $display("FAIL empty_start: got busy=%b v=%b expected 0/0", busy, mem_valid);
        else n_pass++;
    endtask

    task automatic test_ignore_in_run();
        do_clear();
        load(8'h0A); load(8'h4B); load(8'h8C); load(8'hCD);
        start_run(1'b0);
        capture(8, 64'h0, 64'h0, 1'b1);
        model(8, 1'b0, 64'h0, 64'h0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({obs_v[i], obs_d[i], obs_b[i], obs_m[i]} !== {exp_v[i], exp_d[i], exp_b[i], exp_m[i]})
                $display("FAIL ignore cyc%0d: got v/d/b/mem=%b/%b/%b/%h expected %b/%b/%b/%h", i,
                         obs_v[i], obs_d[i], obs_b[i], obs_m[i], exp_v[i], exp_d[i], exp_b[i], exp_m[i]);
            else n_pass++;
        end
        n_checks++;
        if ({count, overflow} !== {5'd4, 1'b0})
            $display("FAIL ignore_count: got count=%0d ovf=%b expected 4/0", count, overflow);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int len;
            bit lp;
            logic [63:0] hp, sp;
            do_clear();
            len = $urandom_range(1, 16);
            for (int k = 0; k < len; k++) load(8'($urandom));
            lp = 1'($urandom_range(0, 1));
            hp = {32'h0, $urandom & $urandom};
            sp = lp ? (64'h1 << $urandom_range(len, 60)) : (64'h1 << 60);
            n_checks++;
            if (count !== 5'(prog_q.size()))
                $display("FAIL rnd%0d_count: got %0d expected %0d", it, count, prog_q.size());
            else n_pass++;
            start_run(lp);
            capture(64, hp, sp, 1'b0);
            model(64, lp, hp, sp);
            for (int i = 0; i < 64; i++) begin
                n_checks++;
                if ({obs_v[i], obs_d[i], obs_b[i], obs_m[i]} !== {exp_v[i], exp_d[i], exp_b[i], exp_m[i]})
                    $display("FAIL rnd%0d cyc%0d: got v/d/b/mem=%b/%b/%b/%h expected %b/%b/%b/%h", it, i,
                             obs_v[i], obs_d[i], obs_b[i], obs_m[i], exp_v[i], exp_d[i], exp_b[i], exp_m[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clear = 1'b0;
        start = 1'b0; loop = 1'b0; stop = 1'b0; hold = 1'b0;
        m_ovf = 1'b0; last_word = 8'h00;
        test_reset();
        test_basic();
        test_overflow();
        test_loop_stop();
        test_hold();
        test_reset_mid_run();
        test_ignore_in_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

- Producer side of the 8-bit instruction-word bus that feeds the accumulator output stage.
- Holds a small program RAM, loaded one word at a time while idle, then streams the stored words out in order, one per enabled cycle, with a valid strobe.
- Each word is formatted {opcode[7:6], operand[5:0]}.
- Sits between the loader/testbench side and the accumulator's `mem` input.

## Interface
- `DEPTH`, 16: program words stored; power of two.
- `AW`, 4: address width, log2(DEPTH).
- `clk`  in  1  system clock; single clock domain, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  write strobe for `wr_data`; honoured only in IDLE.
- `wr_data`  in  8  program word to append.
- `clear`  in  1  empties the program (count and overflow) when in IDLE.
- `start`  in  1  begin streaming; honoured only in IDLE with count > 0.
- `loop`  in  1  sampled with `start`; when set, playback wraps instead of ending.
- `stop`  in  1  abort playback from RUN.
- `hold`  in  1  stall; freezes the read pointer and the output word.
- `mem`  out  8  current program word; reset 8'h00.
- `mem_valid`  out  1  `mem` is a fresh word this cycle; reset 0.
- `busy`  out  1  high in RUN; reset 0.
- `done`  out  1  one-cycle pulse at end of non-loop playback or on stop; reset 0.
- `count`  out  AW+1  stored word count, 0..DEPTH; reset 0.
- `overflow`  out  1  sticky: a write was attempted while full; reset 0.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, `count`=0, write pointer=0, read pointer=0, and all outputs to their reset values. RAM contents are not cleared.
- IDLE write:
  - `wr_en` with `count` < DEPTH stores `wr_data` at address `count`, then `count`+1.
  - `wr_en` while full drops the word and sets `overflow`.
- IDLE clear: `clear` sets `count`=0 and `overflow`=0. `clear` has priority over `wr_en` and `start` in the same cycle.
- Start: `start` with `count`=0 is ignored and the state stays IDLE. Otherwise latch `loop` into `loop_q`, set read pointer=0, and go to RUN.
- RUN with `hold`=0:
  - Register `mem` <= RAM[rd_ptr] and set `mem_valid`=1.
  - If rd_ptr = `count`-1 and `loop_q`=1, rd_ptr wraps to 0 and the state stays RUN.
  - If rd_ptr = `count`-1 and `loop_q`=0, go to DONE.
  - Otherwise rd_ptr+1.
- RUN with `hold`=1: `mem_valid`=0, and `mem` and rd_ptr are unchanged.
- Stop:
  - `stop` in RUN has priority over `hold` and emission.
  - `mem_valid`=0 and the state goes to DONE.
  - A word already emitted stays emitted. No further words are emitted.
- DONE: lasts one cycle. `done`=1 and `mem_valid`=0, then return to IDLE.
- In RUN and DONE, `wr_en`, `clear` and `start` are ignored and leave no side effects.
- `mem` holds its last word after playback. The accumulator qualifies on `mem_valid`.

## Timing
- `start` sampled at edge t; first word on `mem` with `mem_valid`=1 after edge t+1.
- Without hold, N words occupy N consecutive cycles and `done` follows in the next cycle.
- Throughput is 1 word/cycle. Each `hold` cycle adds exactly one cycle of latency.
- Write in cycle t updates `count` after edge t. A `start` in cycle t+1 includes that word.
- `rst` asserted mid-RUN: at the next edge the block is in IDLE with `mem_valid`=0, `busy`=0, `done`=0 and no `done` pulse.
- Loop wrap: word `count`-1 is followed directly by word 0, with no bubble.

## Structure
- Shared package `prog_pkg`:
  - opcode constants OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_HALF=2'b11;
  - field positions OPC_MSB=7, OPC_LSB=6, OPND_MSB=5;
  - sequencer state encoding.
- Sub-module `prog_ram`:
  - DEPTH x 8 register array;
  - synchronous write, combinational read;
  - no reset on the array.
- Top: FSM, write/read pointers, output register.

## Test plan
- Load 8'h05, 8'h43, 8'h82, 8'hC0, then `start` -> `mem` = 05, 43, 82, C0 on 4 consecutive `mem_valid` cycles, `done` the following cycle, then IDLE. The downstream accumulator ends at 6'd3.
- 17 writes of 8'h01..8'h11 -> `count`=16, `overflow`=1, and playback ends with 8'h10 (8'h11 dropped). A `clear` then gives `count`=0 and `overflow`=0.
- Load 8'h05, 8'h41 with `loop`=1, then `start` -> 05, 41, 05, 41 ... with no gaps. `stop` after the third word -> `mem_valid` drops and `done` pulses once.
- 3-word program with `hold` high for 2 cycles after the first word -> `mem_valid` pattern 1,0,0,1,1, `mem` frozen during hold, and `done` on cycle 6 after `start`.
- `rst` during the second word of RUN -> next cycle IDLE with all flags 0 and `count`=0. A `start` with `count`=0 leaves `busy`=0.
- `wr_en` and `start` asserted during RUN -> `count` unchanged and playback unaffected.
